// File: rtl/gnr_attractor_ctrl.sv
// Sequencer and Floyd attractor detector for the GNR node array: search for a tortoise/hare meet, then measure the period.
// Optional macro GNR_ATTR_SNAPSHOT_EN adds attr_state, a snapshot of s0_vec taken when the search phase finds a match.
module gnr_attractor_ctrl #(
    parameter int N_NODES = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [CNT_W-1:0]   max_steps,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
`ifdef GNR_ATTR_SNAPSHOT_EN
    output logic [N_NODES-1:0] attr_state,
`endif
    output logic [N_NODES-1:0] init_state,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SEARCH = 3'd2,
        S_PERIOD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [N_NODES-1:0] r_init_state;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [CNT_W-1:0]   r_per_cnt;
    logic [CNT_W-1:0]   r_meet_steps;
    logic [CNT_W-1:0]   r_period;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
`ifdef GNR_ATTR_SNAPSHOT_EN
    logic [N_NODES-1:0] r_attr_state;
`endif

    logic w_eq;
    logic w_step_nz;
    logic w_per_nz;
    logic w_limit_en;

    assign w_eq       = (s0_vec == s1_vec);
    assign w_step_nz  = (r_step_cnt != C_ZERO);
    assign w_per_nz   = (r_per_cnt != C_ZERO);
    assign w_limit_en = (max_steps != C_ZERO);

    // Main sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_init_state <= {N_NODES{1'b0}};
            r_step_cnt   <= C_ZERO;
            r_per_cnt    <= C_ZERO;
            r_meet_steps <= C_ZERO;
            r_period     <= C_ZERO;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef GNR_ATTR_SNAPSHOT_EN
            r_attr_state <= {N_NODES{1'b0}};
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_init_state <= init_vec;
                        r_step_cnt   <= C_ZERO;
                        r_per_cnt    <= C_ZERO;
                        r_meet_steps <= C_ZERO;
                        r_period     <= C_ZERO;
                        r_timeout    <= 1'b0;
                        r_busy       <= 1'b1;
`ifdef GNR_ATTR_SNAPSHOT_EN
                        r_attr_state <= {N_NODES{1'b0}};
`endif
                        r_state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_state <= S_SEARCH;
                end
                S_SEARCH: begin
                    // A match wins over the step limit in the same cycle.
                    if (w_eq && w_step_nz) begin
                        r_meet_steps <= r_step_cnt;
`ifdef GNR_ATTR_SNAPSHOT_EN
                        r_attr_state <= s0_vec;
`endif
                        r_state      <= S_PERIOD;
                    end else begin
                        if (r_step_cnt != C_ONES) begin
                            r_step_cnt <= r_step_cnt + C_ONE;
                        end
                        if (w_limit_en && (r_step_cnt == max_steps)) begin
                            r_timeout    <= 1'b1;
                            r_meet_steps <= r_step_cnt;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_PERIOD: begin
                    if (w_eq && w_per_nz) begin
                        r_period <= r_per_cnt;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        if (r_per_cnt != C_ONES) begin
                            r_per_cnt <= r_per_cnt + C_ONE;
                        end
                        if (w_limit_en && (r_per_cnt == max_steps)) begin
                            r_timeout <= 1'b1;
                            r_period  <= r_per_cnt;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Node controls decoded from state and the live stream compare.
    always_comb begin
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        case (r_state)
            S_INIT: begin
                reset_nos = 1'b1;
            end
            S_SEARCH: begin
                start_s0 = !(w_eq && w_step_nz);
                start_s1 = !(w_eq && w_step_nz);
            end
            S_PERIOD: begin
                start_s1 = !(w_eq && w_per_nz);
            end
            default: begin
                reset_nos = 1'b0;
            end
        endcase
    end

    assign init_state = r_init_state;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign meet_steps = r_meet_steps;
    assign period     = r_period;
`ifdef GNR_ATTR_SNAPSHOT_EN
    assign attr_state = r_attr_state;
`endif

endmodule
